// File: rtl/bit_serializer_if.sv
// ============================================================================
// bit_serializer_if
// Word handshake and serial output bundle for bit_serializer.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             data_out;
  logic             bit_valid;
  logic             busy;
  logic             frame_done;

  // Producer side: supplies words, observes the serial stream.
  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  data_out,
    input  bit_valid,
    input  busy,
    input  frame_done
  );

  // Serializer side.
  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output data_out,
    output bit_valid,
    output busy,
    output frame_done
  );
endinterface

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// bit_serializer
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock, back-to-back with no idle gap.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  bit_serializer_if.slave      bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dout_q, dout_d;
  logic             bv_q, bv_d;
  logic             busy_q, busy_d;
  logic             fd_q, fd_d;

  logic             w_ready;
  logic             w_xfer;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shift_rest;

  // Ready depends only on state and counter so the producer never sees a
  // combinational path from its own valid.
  assign w_ready = (state_q == S_IDLE) ||
                   ((state_q == S_SHIFT) && (cnt_q == LAST));
  assign w_xfer  = bus.load_valid && w_ready;

  // The first bit leaves straight from load_data; the remainder is parked
  // pre-shifted so the next bit is always at the same end of sreg_q.
  assign w_first_bit  = MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];
  assign w_load_rest  = MSB_FIRST ? (bus.load_data << 1) : (bus.load_data >> 1);
  assign w_next_bit   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign w_shift_rest = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);

  // Next-state and next-output logic; a transfer always starts a fresh word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    dout_d  = IDLE_LEVEL;
    bv_d    = 1'b0;
    busy_d  = 1'b0;
    fd_d    = 1'b0;

    if (w_xfer) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      sreg_d  = w_load_rest;
      dout_d  = w_first_bit;
      bv_d    = 1'b1;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_SHIFT: begin
          if (cnt_q == LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            sreg_d = w_shift_rest;
            dout_d = w_next_bit;
            bv_d   = 1'b1;
            busy_d = 1'b1;
            fd_d   = (cnt_d == LAST);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sreg_d  = '0;
        end
      endcase
    end
  end

  // State and registered outputs; reset discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      dout_q  <= IDLE_LEVEL;
      bv_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      bv_q    <= bv_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.load_ready = w_ready;
  assign bus.data_out   = dout_q;
  assign bus.bit_valid  = bv_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
// tb_bit_serializer
// Directed table-driven bench for bit_serializer: an 8-bit MSB-first
// instance (idle low) and a 4-bit LSB-first instance (idle high).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer;

  logic clk;
  logic reset;

  bit_serializer_if #(.WIDTH(8)) bus_a ();
  bit_serializer_if #(.WIDTH(4)) bus_b ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: inputs applied before it, outputs expected after it.
  typedef struct {
    bit       sel;   // 0 = 8-bit instance, 1 = 4-bit instance
    bit       v;
    bit [7:0] d;
    bit       e_do;
    bit       e_bv;
    bit       e_busy;
    bit       e_fd;
    bit       e_rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add_vec(bit sel, bit v, bit [7:0] d,
                                  bit e_do, bit e_bv, bit e_busy, bit e_fd, bit e_rdy);
    vec_t t;
    t.sel = sel; t.v = v; t.d = d;
    t.e_do = e_do; t.e_bv = e_bv; t.e_busy = e_busy; t.e_fd = e_fd; t.e_rdy = e_rdy;
    vecs.push_back(t);
  endfunction

  // n idle edges with valid low; idle level is 0 on instance A, 1 on B.
  function automatic void add_idle(bit sel, int n);
    for (int i = 0; i < n; i++)
      add_vec(sel, 1'b0, 8'h00, sel, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  // One word of n bits. Edge 0 carries the accepted word (fv/fd); edges
  // i >= rk present rv/rd (must be ignored until the last bit). bits holds
  // the expected serial order, first bit at bits[n-1].
  function automatic void add_word(bit sel, bit [7:0] fdat, bit rv, bit [7:0] rdat,
                                   int rk, bit [7:0] bits, int n);
    for (int i = 0; i < n; i++) begin
      bit       v;
      bit [7:0] d;
      if (i == 0) begin
        v = 1'b1; d = fdat;
      end else if (i >= rk) begin
        v = rv; d = rdat;
      end else begin
        v = 1'b0; d = 8'h00;
      end
      add_vec(sel, v, d, bits[n-1-i], 1'b1, 1'b1, (i == n-1), (i == n-1));
    end
  endfunction

  task automatic chk(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " A data_out"},   bus_a.data_out,   1'b0);
    chk({tag, " A bit_valid"},  bus_a.bit_valid,  1'b0);
    chk({tag, " A busy"},       bus_a.busy,       1'b0);
    chk({tag, " A frame_done"}, bus_a.frame_done, 1'b0);
    chk({tag, " A load_ready"}, bus_a.load_ready, 1'b1);
    chk({tag, " B data_out"},   bus_b.data_out,   1'b1);
  endtask

  initial begin
    logic o_do, o_bv, o_busy, o_fd, o_rdy;
    string nm;

    // Reset and idle after release (instance A).
    add_idle(0, 4);
    // 0xA5 single word, then idle.
    add_word(0, 8'hA5, 1'b0, 8'h00, 8, 8'b10100101, 8);
    add_idle(0, 2);
    // Back-to-back 0xA0 then 0x0A with valid held; 0x0A waits, then no gap.
    add_word(0, 8'hA0, 1'b1, 8'h0A, 1, 8'b10100000, 8);
    add_word(0, 8'h0A, 1'b0, 8'h00, 8, 8'b00001010, 8);
    add_idle(0, 2);
    // 0xFF offered during bit 3 of 0x00: ignored until the last bit.
    add_word(0, 8'h00, 1'b1, 8'hFF, 3, 8'b00000000, 8);
    add_word(0, 8'hFF, 1'b0, 8'h00, 8, 8'b11111111, 8);
    add_idle(0, 2);
    // 4-bit LSB-first instance, idle high: 0x5 -> 1,0,1,0.
    add_idle(1, 2);
    add_word(1, 8'h05, 1'b0, 8'h00, 4, 8'b00001010, 4);
    add_idle(1, 2);

    bus_a.load_valid = 1'b0; bus_a.load_data = '0;
    bus_b.load_valid = 1'b0; bus_b.load_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus_a.load_valid = 1'b0;
      bus_b.load_valid = 1'b0;
      if (vecs[i].sel == 1'b0) begin
        bus_a.load_valid = vecs[i].v;
        bus_a.load_data  = vecs[i].d;
      end else begin
        bus_b.load_valid = vecs[i].v;
        bus_b.load_data  = vecs[i].d[3:0];
      end
      @(posedge clk);
      #1;
      if (vecs[i].sel == 1'b0) begin
        o_do = bus_a.data_out; o_bv = bus_a.bit_valid; o_busy = bus_a.busy;
        o_fd = bus_a.frame_done; o_rdy = bus_a.load_ready;
      end else begin
        o_do = bus_b.data_out; o_bv = bus_b.bit_valid; o_busy = bus_b.busy;
        o_fd = bus_b.frame_done; o_rdy = bus_b.load_ready;
      end
      nm = $sformatf("vec%0d", i);
      chk({nm, " data_out"},   o_do,   vecs[i].e_do);
      chk({nm, " bit_valid"},  o_bv,   vecs[i].e_bv);
      chk({nm, " busy"},       o_busy, vecs[i].e_busy);
      chk({nm, " frame_done"}, o_fd,   vecs[i].e_fd);
      chk({nm, " load_ready"}, o_rdy,  vecs[i].e_rdy);
    end

    // Asynchronous reset during bit 3 of 0xA5 (bits 1,0,1 so far).
    @(negedge clk);
    bus_a.load_valid = 1'b1;
    bus_a.load_data  = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    bus_a.load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midword bit3 data_out",  bus_a.data_out,  1'b1);
    chk("midword bit3 bit_valid", bus_a.bit_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      nm = $sformatf("post_reset%0d", i);
      chk({nm, " data_out"},   bus_a.data_out,   1'b0);
      chk({nm, " bit_valid"},  bus_a.bit_valid,  1'b0);
      chk({nm, " busy"},       bus_a.busy,       1'b0);
      chk({nm, " frame_done"}, bus_a.frame_done, 1'b0);
      chk({nm, " load_ready"}, bus_a.load_ready, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
